// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: next-PC FSM states and default PC constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_INC      = 4;

endpackage

// File: rtl/pc_prio_enc.sv
// Fixed-priority encoder: request 0 has highest priority.
module pc_prio_enc #(
  parameter int NSRC = 3,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [IW-1:0]   index
);

  always_comb begin
    any   = |req;
    index = '0;
    // Scan from lowest priority upward so the lowest set index wins last.
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (req[i-1]) index = IW'(i - 1);
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC unit: fetch PC register with prioritised redirects, boot hold,
// stall support and a pending-redirect latch for redirects seen under stall.
module pc_next_unit
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NSRC        = 3,
  parameter int unsigned      INC         = DEFAULT_INC,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEFAULT_RESET_PC),
  parameter int unsigned      BOOT_CYCLES = 1,
  localparam int              SW          = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NSRC-1:0]       redir_valid,
  input  logic [NSRC*WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0]      pc,
  output logic                  pc_valid,
  output logic                  redir_taken,
  output logic [SW-1:0]         redir_src,
  output logic                  pending
);

  localparam int CW = $clog2(BOOT_CYCLES + 1);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;
  logic [SW-1:0]    src_q, src_d;
  logic [WIDTH-1:0] lat_tgt_q, lat_tgt_d;
  logic [SW-1:0]    lat_idx_q, lat_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             win_any;
  logic [SW-1:0]    win_idx;
  logic [WIDTH-1:0] win_tgt;

  pc_prio_enc #(
    .NSRC (NSRC),
    .IW   (SW)
  ) u_prio (
    .req   (redir_valid),
    .any   (win_any),
    .index (win_idx)
  );

  always_comb begin
    win_tgt = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (SW'(i) == win_idx) win_tgt = redir_target[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    taken_d   = 1'b0;
    src_d     = src_q;
    lat_tgt_d = lat_tgt_q;
    lat_idx_d = lat_idx_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (win_any) begin
            pc_d    = win_tgt;
            taken_d = 1'b1;
            src_d   = win_idx;
          end else begin
            pc_d = pc_q + WIDTH'(INC);
          end
        end else if (win_any) begin
          lat_tgt_d = win_tgt;
          lat_idx_d = win_idx;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (stall) begin
          if (win_any) begin
            lat_tgt_d = win_tgt;
            lat_idx_d = win_idx;
          end
        end else begin
          // A live redirect on release is newer than the latched one.
          taken_d = 1'b1;
          state_d = ST_RUN;
          if (win_any) begin
            pc_d  = win_tgt;
            src_d = win_idx;
          end else begin
            pc_d  = lat_tgt_q;
            src_d = lat_idx_q;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      taken_q   <= 1'b0;
      src_q     <= '0;
      lat_tgt_q <= '0;
      lat_idx_q <= '0;
      cnt_q     <= CW'(BOOT_CYCLES);
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      src_q     <= src_d;
      lat_tgt_q <= lat_tgt_d;
      lat_idx_q <= lat_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = (state_q != ST_BOOT);
  assign redir_taken = taken_q;
  assign redir_src   = src_q;
  assign pending     = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a 32-bit default instance and an 8-bit, 3-cycle-boot
// instance, both checked every cycle against a behavioural reference model.
module tb_pc_next_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rA, sA;
  logic [2:0]  vA;
  logic [95:0] tA;
  logic [31:0] pcA;
  logic        validA, takenA, pendA;
  logic [1:0]  srcA;

  logic        rB, sB;
  logic [2:0]  vB;
  logic [23:0] tB;
  logic [7:0]  pcB;
  logic        validB, takenB, pendB;
  logic [1:0]  srcB;

  assign tB = {tA[64 +: 8], tA[32 +: 8], tA[0 +: 8]};

  pc_next_unit #(
    .WIDTH       (32),
    .NSRC        (3),
    .INC         (4),
    .RESET_PC    (32'h0),
    .BOOT_CYCLES (1)
  ) dut_a (
    .clk          (clk),
    .reset        (rA),
    .stall        (sA),
    .redir_valid  (vA),
    .redir_target (tA),
    .pc           (pcA),
    .pc_valid     (validA),
    .redir_taken  (takenA),
    .redir_src    (srcA),
    .pending      (pendA)
  );

  pc_next_unit #(
    .WIDTH       (8),
    .NSRC        (3),
    .INC         (4),
    .RESET_PC    (8'hF0),
    .BOOT_CYCLES (3)
  ) dut_b (
    .clk          (clk),
    .reset        (rB),
    .stall        (sB),
    .redir_valid  (vB),
    .redir_target (tB),
    .pc           (pcB),
    .pc_valid     (validB),
    .redir_taken  (takenB),
    .redir_src    (srcB),
    .pending      (pendB)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          valid;
    int          boot_left;
    bit          pend;
    logic [31:0] lt;
    int          li;
    bit          taken;
    int          src;
    bit          src_known;
  } model_t;

  model_t mA, mB;

  // Reference behaviour stated directly from the operating rules.
  function automatic model_t mstep(model_t m, bit rst, bit stl, logic [2:0] v,
                                   logic [95:0] t, int boot, logic [31:0] rpc,
                                   logic [31:0] mask);
    model_t n;
    int w;
    logic [31:0] tw;
    n = m;
    w = -1;
    for (int i = 0; i < 3; i++) if (v[i] && w < 0) w = i;
    tw = (w >= 0) ? (t[w*32 +: 32] & mask) : 32'h0;
    n.taken = 0;
    n.src_known = 0;
    if (rst) begin
      n.pc = rpc; n.valid = 0; n.boot_left = boot; n.pend = 0;
      n.src = 0; n.src_known = 1;
      return n;
    end
    if (!m.valid) begin
      n.boot_left = m.boot_left - 1;
      if (n.boot_left == 0) n.valid = 1;
      return n;
    end
    if (!m.pend) begin
      if (!stl) begin
        if (w >= 0) begin
          n.pc = tw; n.taken = 1; n.src = w; n.src_known = 1;
        end else n.pc = (m.pc + 4) & mask;
      end else if (w >= 0) begin
        n.pend = 1; n.lt = tw; n.li = w;
      end
    end else begin
      if (stl) begin
        if (w >= 0) begin n.lt = tw; n.li = w; end
      end else begin
        n.taken = 1; n.pend = 0; n.src_known = 1;
        if (w >= 0) begin n.pc = tw; n.src = w; end
        else begin n.pc = m.lt; n.src = m.li; end
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    mA = mstep(mA, rA, sA, vA, tA, 1, 32'h0, 32'hFFFF_FFFF);
    mB = mstep(mB, rB, sB, vB, tA, 3, 32'hF0, 32'hFF);
    #1;
    check("A_pc", pcA, mA.pc);
    check("A_valid", validA, mA.valid);
    check("A_taken", takenA, mA.taken);
    check("A_pending", pendA, mA.pend);
    if (mA.src_known) check("A_src", srcA, mA.src);
    check("B_pc", pcB, mB.pc);
    check("B_valid", validB, mB.valid);
    check("B_taken", takenB, mB.taken);
    check("B_pending", pendB, mB.pend);
    if (mB.src_known) check("B_src", srcB, mB.src);
  endtask

  initial begin
    rA = 1; sA = 0; vA = '0; tA = '0;
    rB = 1; sB = 0; vB = '0;
    mA = '{default: 0};
    mB = '{default: 0};
    #2;
    tick();
    check("A_reset_valid", validA, 0);
    check("B_reset_pc", pcB, 32'hF0);

    // A idles after reset; B sees redirects during its boot window.
    rA = 0; rB = 0; vB = 3'b111;
    tA = {32'h200, 32'h100, 32'h40};
    tick();
    check("A_boot_done_pc", pcA, 0);
    check("A_boot_done_valid", validA, 1);
    check("B_boot_hold", validB, 0);
    tick();
    check("A_inc1", pcA, 4);
    tick();
    check("A_inc2", pcA, 8);
    check("B_valid_3rd_edge", validB, 1);
    check("B_pc_after_boot", pcB, 32'hF0);
    vB = '0;
    tick();
    check("A_inc3", pcA, 12);
    tick();
    tick();
    check("B_pc_FC", pcB, 32'hFC);
    tick();
    check("B_wrap", pcB, 32'h00);

    // Simultaneous sources: src1 beats src2.
    vA = 3'b110;
    tick();
    check("A_prio_pc", pcA, 32'h100);
    check("A_prio_src", srcA, 1);
    vA = '0;
    tick();
    check("A_after_redir", pcA, 32'h104);

    // Newest redirect under stall wins at release.
    sA = 1; vA = 3'b100;
    tick();
    check("A_pend_set", pendA, 1);
    vA = 3'b001;
    tick();
    vA = '0;
    tick();
    check("A_stall_hold", pcA, 32'h104);
    sA = 0;
    tick();
    check("A_release_pc", pcA, 32'h40);
    check("A_release_src", srcA, 0);
    check("A_release_pend", pendA, 0);

    // Live redirect on release beats the latch.
    sA = 1; vA = 3'b100;
    tick();
    sA = 0; vA = 3'b010; tA[32 +: 32] = 32'h300;
    tick();
    check("A_live_wins", pcA, 32'h300);
    vA = '0;
    tick();
    check("A_latch_dropped", pcA, 32'h304);

    // Reset while pending.
    sA = 1; vA = 3'b001;
    tick();
    rA = 1;
    tick();
    check("A_rst_pend_pc", pcA, 0);
    check("A_rst_pend_pending", pendA, 0);
    rA = 0; sA = 0; vA = '0;

    for (int unsigned c = 0; c < 600; c++) begin
      rA = ($urandom_range(0, 49) == 0);
      rB = ($urandom_range(0, 49) == 0);
      sA = ($urandom_range(0, 9) < 4);
      sB = ($urandom_range(0, 9) < 4);
      vA = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      vB = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      tA = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 19) == 0) tA[0 +: 32] = 32'hFFFF_FFFC;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
